// File: rtl/clock_defs_57.sv
// Shared timing constants and key FSM encodings.
// Reused by the key, debounce and stopwatch blocks.
package clock_defs_57;

    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int DEF_DEBOUNCE_MS = 20;
    localparam int DEF_LONG_MS     = 1000;
    localparam int DEF_REPEAT_MS   = 200;

    // Width of the millisecond window counter (windows up to 2047 ms)
    localparam int MS_CNT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } key_state_t;

    // Convert a millisecond parameter to the counter width
    function automatic logic [MS_CNT_W-1:0] ms_const(input int ms);
        logic [31:0] v;
        v = ms;
        return v[MS_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ms_tick_57.sv
// Free-running millisecond prescaler.
// Emits a registered one-cycle tick on every counter wrap.
module ms_tick_57 #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk_50m_57,
    input  logic rst_57,
    output logic ms_tick_57
);

    localparam int DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
    localparam int W   = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    // Count 0..DIV-1 and flag the wrap cycle
    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            div_cnt    <= '0;
            ms_tick_57 <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt    <= '0;
            ms_tick_57 <= 1'b1;
        end else begin
            div_cnt    <= div_cnt + 1'b1;
            ms_tick_57 <= 1'b0;
        end
    end

endmodule

// File: rtl/key_event_57.sv
// Debounced key with press / short / long / auto-repeat events.
// One instance per physical key; all outputs are registered.
module key_event_57
    import clock_defs_57::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
    input  logic clk_50m_57,
    input  logic rst_57,
    input  logic key_in_57,
    output logic key_level_57,
    output logic press_pulse_57,
    output logic short_pulse_57,
    output logic long_pulse_57,
    output logic repeat_pulse_57
);

    localparam logic [MS_CNT_W-1:0] DB_T   = ms_const(DEBOUNCE_MS);
    localparam logic [MS_CNT_W-1:0] LONG_T = ms_const(LONG_MS);
    localparam logic [MS_CNT_W-1:0] REP_T  = ms_const(REPEAT_MS);

    logic [1:0]          sync_q;
    logic                key_s;
    logic                ms_tick;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic                long_flag;
    key_state_t          state;

    assign key_s = sync_q[1];

    ms_tick_57 #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_tick (
        .clk_50m_57(clk_50m_57),
        .rst_57    (rst_57),
        .ms_tick_57(ms_tick)
    );

    // Two-flop synchronizer for the raw key level
    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_in_57};
        end
    end

    // Key FSM: key_s changes win over window expiry in the same cycle
    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            state           <= ST_IDLE;
            ms_cnt          <= '0;
            long_flag       <= 1'b0;
            key_level_57    <= 1'b0;
            press_pulse_57  <= 1'b0;
            short_pulse_57  <= 1'b0;
            long_pulse_57   <= 1'b0;
            repeat_pulse_57 <= 1'b0;
        end else begin
            press_pulse_57  <= 1'b0;
            short_pulse_57  <= 1'b0;
            long_pulse_57   <= 1'b0;
            repeat_pulse_57 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ms_cnt <= '0;
                    if (key_s) begin
                        state <= ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (!key_s) begin
                        state  <= ST_IDLE;
                        ms_cnt <= '0;
                    end else if (ms_cnt == DB_T) begin
                        state          <= ST_HELD;
                        ms_cnt         <= '0;
                        press_pulse_57 <= 1'b1;
                        key_level_57   <= 1'b1;
                        long_flag      <= 1'b0;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!key_s) begin
                        state  <= ST_RELEASE_DB;
                        ms_cnt <= '0;
                    end else if (ms_cnt == LONG_T) begin
                        state         <= ST_REPEAT;
                        ms_cnt        <= '0;
                        long_pulse_57 <= 1'b1;
                        long_flag     <= 1'b1;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!key_s) begin
                        state  <= ST_RELEASE_DB;
                        ms_cnt <= '0;
                    end else if (ms_cnt == REP_T) begin
                        ms_cnt          <= '0;
                        repeat_pulse_57 <= 1'b1;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                ST_RELEASE_DB: begin
                    if (key_s) begin
                        state  <= long_flag ? ST_REPEAT : ST_HELD;
                        ms_cnt <= '0;
                    end else if (ms_cnt == DB_T) begin
                        state          <= ST_IDLE;
                        ms_cnt         <= '0;
                        key_level_57   <= 1'b0;
                        short_pulse_57 <= !long_flag;
                    end else if (ms_tick) begin
                        ms_cnt <= ms_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_57.sv
// Bench for key_event_57 at 10 cycles/ms, debounce 2, long 10, repeat 3.
// Pulses are matched in order against a queue of expected timed events.
module tb_key_event_57;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key = 1'b0;
    logic level;
    logic p_press;
    logic p_short;
    logic p_long;
    logic p_rep;

    always #5 clk = ~clk;

    key_event_57 #(
        .CLK_HZ     (10_000),
        .DEBOUNCE_MS(2),
        .LONG_MS    (10),
        .REPEAT_MS  (3)
    ) dut (
        .clk_50m_57     (clk),
        .rst_57         (rst),
        .key_in_57      (key),
        .key_level_57   (level),
        .press_pulse_57 (p_press),
        .short_pulse_57 (p_short),
        .long_pulse_57  (p_long),
        .repeat_pulse_57(p_rep)
    );

    typedef struct {
        int kind;
        int tmin;
        int tmax;
    } exp_t;

    typedef struct {
        string name;
        int    hi1;
        int    lo1;
        int    hi2;
        int    lo2;
        int    nev;
        int    kind[4];
        int    tmin[4];
        int    tmax[4];
        int    rises;
    } vec_t;

    exp_t sb[$];
    vec_t vt[5];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rises    = 0;
    logic lvl_prev = 1'b0;

    function automatic string kname(input int k);
        case (k)
            0: return "press";
            1: return "short";
            2: return "long";
            default: return "repeat";
        endcase
    endfunction

    task automatic push(input int k, input int t0, input int lo, input int hi);
        exp_t e;
        e.kind = k;
        e.tmin = t0 + lo;
        e.tmax = t0 + hi;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Called once per negedge: match pulses against the scoreboard
    task automatic sample();
        logic [3:0] p;
        int k;
        exp_t e;
        p = {p_rep, p_long, p_short, p_press};
        if (p != 4'b0000) begin
            chk("onehot", $countones(p), 1);
            k = p_press ? 0 : p_short ? 1 : p_long ? 2 : 3;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected %s pulse at cyc %0d, none required",
                         kname(k), cyc);
            end else begin
                e = sb.pop_front();
                if (e.kind != k || cyc < e.tmin || cyc > e.tmax) begin
                    n_fail++;
                    $display("FAIL event: got %s at cyc %0d, required %s in [%0d,%0d]",
                             kname(k), cyc, kname(e.kind), e.tmin, e.tmax);
                end
            end
        end
        if (level && !lvl_prev) rises++;
        lvl_prev = level;
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            sample();
        end
    endtask

    initial begin
        int t0;
        int bound;

        vt[0] = '{"short_press", 50, 100, 0, 0, 2,
                  '{0, 1, 0, 0}, '{13, 63, 0, 0}, '{26, 76, 0, 0}, 1};
        vt[1] = '{"glitch_1cyc", 1, 60, 0, 0, 0,
                  '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0};
        vt[2] = '{"glitch_8cyc", 8, 60, 0, 0, 0,
                  '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0};
        vt[3] = '{"long_hold", 200, 60, 0, 0, 4,
                  '{0, 2, 3, 3}, '{13, 112, 142, 172}, '{26, 126, 156, 186}, 1};
        vt[4] = '{"release_bounce", 50, 5, 115, 60, 2,
                  '{0, 2, 0, 0}, '{13, 148, 0, 0}, '{26, 161, 0, 0}, 1};

        // Reset state
        cycle(3);
        chk("rst_level", int'(level), 0);
        chk("rst_press", int'(p_press), 0);
        chk("rst_short", int'(p_short), 0);
        chk("rst_long", int'(p_long), 0);
        chk("rst_repeat", int'(p_rep), 0);
        rst = 1'b1;
        cycle(20);

        // Table-driven key waveforms
        for (int i = 0; i < 5; i++) begin
            rises = 0;
            t0 = cyc;
            for (int j = 0; j < vt[i].nev; j++) begin
                push(vt[i].kind[j], t0, vt[i].tmin[j], vt[i].tmax[j]);
            end
            key = 1'b1;
            cycle(vt[i].hi1);
            key = 1'b0;
            cycle(vt[i].lo1);
            if (vt[i].hi2 > 0) begin
                key = 1'b1;
                cycle(vt[i].hi2);
                key = 1'b0;
                cycle(vt[i].lo2);
            end
            chk({vt[i].name, "_missing"}, sb.size(), 0);
            chk({vt[i].name, "_rises"}, rises, vt[i].rises);
            chk({vt[i].name, "_level_end"}, int'(level), 0);
            sb.delete();
        end

        // Reset while in REPEAT with the key still held
        rises = 0;
        t0 = cyc;
        push(0, t0, 13, 26);
        push(2, t0, 112, 126);
        push(3, t0, 142, 156);
        key = 1'b1;
        bound = 0;
        while (sb.size() != 0 && bound < 300) begin
            cycle(1);
            bound++;
        end
        chk("repeat_reached", sb.size(), 0);
        sb.delete();
        chk("pre_rst_level", int'(level), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_pulses", int'({p_rep, p_long, p_short, p_press}), 0);
        cycle(3);
        chk("rst_hold_level", int'(level), 0);
        rst = 1'b1;
        t0 = cyc;
        push(0, t0, 13, 26);
        cycle(40);
        chk("requal_missing", sb.size(), 0);
        chk("requal_level", int'(level), 1);
        t0 = cyc;
        push(1, t0, 13, 26);
        key = 1'b0;
        cycle(40);
        chk("requal_short_missing", sb.size(), 0);
        chk("requal_level_end", int'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
